barrier_probe_sched: RTL and testbench
======================================

# barrier_probe_sched

Shared-resource scheduler that gives every moving object (two tanks, two shells) its per-frame 4-bit barrier-collision vector from a single barrier-map lookup port. On each frame strobe it snapshots all requester positions. It then issues up to four edge probes per requester to the lookup unit over a req/ack handshake and publishes all collision vectors atomically before the next frame. It sits between the barrier-map ROM/lookup unit and the tank/shell motion modules, driving their `barrier_collision` inputs.

## Interface
- `N_REQ`, 4, number of requesters (index 0 = P1 tank, 1 = P2 tank, 2 = P1 shell, 3 = P2 shell)
- `TIMEOUT`, 15, max cycles to wait for `lk_ack` per probe
- `X_MAX`, 639, rightmost legal screen X
- `Y_MAX`, 479, bottommost legal screen Y

- `Clk` in 1 system clock; the only clock
- `Reset` in 1 asynchronous, active-high reset
- `frame_clk` in 1 frame strobe level, synchronous to `Clk`; rising edge starts a sweep
- `req_x` in N_REQ*10 packed centre X per requester
- `req_y` in N_REQ*10 packed centre Y
- `req_s` in N_REQ*10 packed half-size
- `lk_req` out 1 lookup request
- `lk_x` out 10 probe X, stable while `lk_req`=1
- `lk_y` out 10 probe Y, stable while `lk_req`=1
- `lk_ack` in 1 lookup done; `lk_hit` valid in the same cycle
- `lk_hit` in 1 probe pixel is a barrier
- `collision` out N_REQ*4 per requester: [0] right probe, [1] left, [2] down, [3] up
- `coll_valid` out 1 one-cycle pulse when `collision` updates
- `busy` out 1 sweep in progress
- `overrun` out 1 sticky: frame edge arrived during a sweep
- `timeout_err` out 1 sticky: a probe timed out

## Operation
- FSM states: IDLE, SNAP, CHECK, REQ, GAP, PUBLISH.
- IDLE: a rising edge of `frame_clk` (one-register edge detect) or a pending flag moves to SNAP.
- SNAP (1 cycle): latch all `req_x/y/s`; clear the scratch vector; requester idx=0, probe=0.
- CHECK (1 cycle): compute the probe coordinate, working 11 bits wide:
  - right = (X+S+1, Y); left = (X−S−1, Y); down = (X, Y+S+1); up = (X, Y−S−1).
  - If the coordinate is out of bounds (X+S+1 > X_MAX, X < S+1, Y+S+1 > Y_MAX, or Y < S+1), set the scratch bit to 1 without querying and advance.
  - Otherwise go to REQ.
- REQ: `lk_req`=1 with registered `lk_x/y`.
  - On `lk_ack`, scratch bit ← `lk_hit`; go to GAP.
  - If no ack after TIMEOUT cycles, scratch bit ← 1, set `timeout_err`, go to GAP.
- GAP (1 cycle): `lk_req`=0; advance the probe, then the requester. After the last probe of the last requester go to PUBLISH, otherwise go to CHECK.
- PUBLISH (1 cycle): copy scratch to `collision`; pulse `coll_valid`; go to IDLE.
- A frame edge while `busy` sets `overrun` and a one-deep pending flag. The current sweep completes unaltered, then a new sweep starts from IDLE. Further edges while pending are absorbed.
- `lk_ack` while `lk_req`=0 is ignored. The lookup unit must drop any in-flight request when `lk_req` falls.
- `collision` changes only in PUBLISH, so consumers never see a mixed frame.

## Timing
- Reset values:
  - FSM=IDLE, `lk_req`=0, `lk_x`=`lk_y`=0.
  - `collision` = all ones (every direction blocked until the first publish).
  - `coll_valid`=0, `busy`=0, `overrun`=0, `timeout_err`=0, pending=0.
- Reset is honoured mid-sweep: `lk_req` drops immediately (asynchronously).
- Sweep start: SNAP is entered the cycle after the `Clk` edge that samples `frame_clk` high following low.
- Per probe with zero-wait ack (ack in the first REQ cycle): CHECK + REQ + GAP = 3 cycles. Out-of-bounds probe: CHECK + GAP = 2 cycles.
- Full sweep at N_REQ=4, all probes queried, zero-wait: 1 + 16×3 + 1 = 50 cycles from SNAP to PUBLISH. `collision` and `coll_valid` are visible after the PUBLISH edge.
- `busy` is high from SNAP through PUBLISH inclusive.
- Timed-out probe: occupies exactly TIMEOUT REQ cycles.

## Structure
- Shared package `tank_pkg`:
  - `probe_e` enum (PROBE_R=0, PROBE_L=1, PROBE_D=2, PROBE_U=3), whose values equal the collision bit indices.
  - `sched_state_e` enum.
  - Screen constants 639/479.
- Sub-module `probe_coord`: combinational 11-bit coordinate and out-of-bounds computation from (X, Y, S, probe). It is instantiated once in the scheduler.

## Test plan
- Reset, then no frame edge → `collision`=16'hFFFF, `lk_req`=0, `busy`=0.
- Tank0 at (160,240) S=8, lookup zero-wait with `lk_hit`=1 only at (169,240); other requesters mid-screen → probes issued at (169,240), (151,240), (160,249), (160,231). `collision[3:0]`=4'b0001; `coll_valid` pulses once 50 cycles after SNAP.
- Requester at (5,240) S=8 → left probe skipped (no `lk_req` at X<0), bit[1]=1.
- Lookup never acks for one probe → exactly 15 REQ cycles, then that bit=1, `timeout_err`=1, sweep completes.
- Second `frame_clk` edge at sweep cycle 20 → `overrun`=1; a second sweep starts immediately after PUBLISH; two `coll_valid` pulses total.
- `Reset` asserted during REQ → `lk_req` low the same cycle; `collision` returns to all ones.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and screen limits for the tank game blocks.
// Probe enum values double as collision bit indices.
package tank_pkg;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int COORD_W      = 10;

    typedef enum logic [1:0] {
        PROBE_R = 2'd0,
        PROBE_L = 2'd1,
        PROBE_D = 2'd2,
        PROBE_U = 2'd3
    } probe_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_CHECK,
        ST_REQ,
        ST_GAP,
        ST_PUBLISH
    } sched_state_e;

endpackage

// File: rtl/probe_coord.sv
// Edge-probe coordinate for one requester/direction, with screen bounds check.
// All arithmetic is 11 bits so X+S+1 and X-S-1 cannot wrap silently.
module probe_coord
    import tank_pkg::*;
#(
    parameter int X_MAX = SCREEN_X_MAX,
    parameter int Y_MAX = SCREEN_Y_MAX
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_s,
    input  probe_e             i_probe,
    output logic [COORD_W-1:0] o_px,
    output logic [COORD_W-1:0] o_py,
    output logic               o_oob
);

    logic [COORD_W:0] w_s1;
    logic [COORD_W:0] w_xp;
    logic [COORD_W:0] w_xm;
    logic [COORD_W:0] w_yp;
    logic [COORD_W:0] w_ym;

    assign w_s1 = {1'b0, i_s} + 11'd1;
    assign w_xp = {1'b0, i_x} + w_s1;
    assign w_xm = {1'b0, i_x} - w_s1;
    assign w_yp = {1'b0, i_y} + w_s1;
    assign w_ym = {1'b0, i_y} - w_s1;

    // Bit 10 of the differences is the borrow: set exactly when X < S+1.
    always_comb begin
        o_px  = i_x;
        o_py  = i_y;
        o_oob = 1'b0;
        unique case (i_probe)
            PROBE_R: begin
                o_px  = w_xp[COORD_W-1:0];
                o_oob = (w_xp > 11'(X_MAX));
            end
            PROBE_L: begin
                o_px  = w_xm[COORD_W-1:0];
                o_oob = w_xm[COORD_W];
            end
            PROBE_D: begin
                o_py  = w_yp[COORD_W-1:0];
                o_oob = (w_yp > 11'(Y_MAX));
            end
            PROBE_U: begin
                o_py  = w_ym[COORD_W-1:0];
                o_oob = w_ym[COORD_W];
            end
        endcase
    end

endmodule

// File: rtl/barrier_probe_sched.sv
// Per-frame barrier collision scheduler: snapshots all requesters, walks their four
// edge probes through one shared lookup port, and publishes every vector at once.
module barrier_probe_sched
    import tank_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int X_MAX   = SCREEN_X_MAX,
    parameter int Y_MAX   = SCREEN_Y_MAX
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [N_REQ*10-1:0]    req_x,
    input  logic [N_REQ*10-1:0]    req_y,
    input  logic [N_REQ*10-1:0]    req_s,
    output logic                   lk_req,
    output logic [9:0]             lk_x,
    output logic [9:0]             lk_y,
    input  logic                   lk_ack,
    input  logic                   lk_hit,
    output logic [N_REQ*4-1:0]     collision,
    output logic                   coll_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    sched_state_e r_state;
    sched_state_e w_nxt;

    logic                          r_frame_d;
    logic                          r_pend;
    logic                          r_overrun;
    logic                          r_tmo_err;
    logic                          r_lk_req;
    logic [9:0]                    r_lk_x;
    logic [9:0]                    r_lk_y;
    logic                          r_coll_valid;
    logic [N_REQ-1:0][COORD_W-1:0] r_x;
    logic [N_REQ-1:0][COORD_W-1:0] r_y;
    logic [N_REQ-1:0][COORD_W-1:0] r_s;
    logic [N_REQ-1:0][3:0]         r_scratch;
    logic [N_REQ-1:0][3:0]         r_coll;
    logic [IW-1:0]                 r_idx;
    probe_e                        r_probe;
    logic [WW-1:0]                 r_wait;

    logic                          w_rise;
    logic                          w_last;
    logic                          w_tmo;
    logic [COORD_W-1:0]            w_px;
    logic [COORD_W-1:0]            w_py;
    logic                          w_oob;

    assign w_rise = frame_clk & ~r_frame_d;
    assign w_last = (r_idx == IW'(N_REQ - 1)) && (r_probe == PROBE_U);
    assign w_tmo  = (r_wait == WW'(TIMEOUT - 1));

    probe_coord #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_coord (
        .i_x     (r_x[r_idx]),
        .i_y     (r_y[r_idx]),
        .i_s     (r_s[r_idx]),
        .i_probe (r_probe),
        .o_px    (w_px),
        .o_py    (w_py),
        .o_oob   (w_oob)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_rise || r_pend) w_nxt = ST_SNAP;
            ST_SNAP:    w_nxt = ST_CHECK;
            ST_CHECK:   w_nxt = w_oob ? ST_GAP : ST_REQ;
            ST_REQ:     if (lk_ack || w_tmo) w_nxt = ST_GAP;
            ST_GAP:     w_nxt = w_last ? ST_PUBLISH : ST_CHECK;
            ST_PUBLISH: w_nxt = ST_IDLE;
            default:    w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_d    <= 1'b0;
            r_pend       <= 1'b0;
            r_overrun    <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_lk_req     <= 1'b0;
            r_lk_x       <= '0;
            r_lk_y       <= '0;
            r_coll_valid <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_s          <= '0;
            r_scratch    <= '0;
            r_coll       <= '1;
            r_idx        <= '0;
            r_probe      <= PROBE_R;
            r_wait       <= '0;
        end else begin
            r_frame_d    <= frame_clk;
            r_lk_req     <= (w_nxt == ST_REQ);
            r_coll_valid <= (r_state == ST_PUBLISH);

            // One-deep pending: extra edges while already pending are absorbed.
            if (w_rise && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
                r_pend    <= 1'b1;
            end else if (r_state == ST_IDLE && r_pend) begin
                r_pend    <= 1'b0;
            end

            case (r_state)
                ST_SNAP: begin
                    r_x       <= req_x;
                    r_y       <= req_y;
                    r_s       <= req_s;
                    r_scratch <= '0;
                    r_idx     <= '0;
                    r_probe   <= PROBE_R;
                end
                ST_CHECK: begin
                    r_wait <= '0;
                    if (w_oob) begin
                        r_scratch[r_idx][r_probe] <= 1'b1;
                    end else begin
                        r_lk_x <= w_px;
                        r_lk_y <= w_py;
                    end
                end
                ST_REQ: begin
                    if (lk_ack) begin
                        r_scratch[r_idx][r_probe] <= lk_hit;
                    end else if (w_tmo) begin
                        r_scratch[r_idx][r_probe] <= 1'b1;
                        r_tmo_err                 <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                ST_GAP: begin
                    if (r_probe == PROBE_U) begin
                        r_probe <= PROBE_R;
                        r_idx   <= r_idx + IW'(1);
                    end else begin
                        r_probe <= probe_e'(r_probe + 2'd1);
                    end
                end
                ST_PUBLISH: r_coll <= r_scratch;
                default: ;
            endcase
        end
    end

    assign lk_req      = r_lk_req;
    assign lk_x        = r_lk_x;
    assign lk_y        = r_lk_y;
    assign collision   = r_coll;
    assign coll_valid  = r_coll_valid;
    assign busy        = (r_state != ST_IDLE);
    assign overrun     = r_overrun;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_barrier_probe_sched.sv
// Bench for barrier_probe_sched: lookup responder, sweep-level reference model with a
// per-cycle compare process, and directed scenarios with hand-computed expectations.
module tb_barrier_probe_sched;

    localparam int N = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic [N*10-1:0] req_x = '0;
    logic [N*10-1:0] req_y = '0;
    logic [N*10-1:0] req_s = '0;
    logic          lk_req;
    logic [9:0]    lk_x, lk_y;
    logic          lk_ack, lk_hit;
    logic [N*4-1:0] collision;
    logic          coll_valid, busy, overrun, timeout_err;

    logic          stray_ack = 1'b0;
    logic          na_en = 1'b0;
    logic [9:0]    na_x = '0;
    logic [9:0]    na_y = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    barrier_probe_sched #(.N_REQ(N), .TIMEOUT(TMO), .X_MAX(639), .Y_MAX(479)) dut (
        .Clk(clk), .Reset(Reset), .frame_clk(frame_clk),
        .req_x(req_x), .req_y(req_y), .req_s(req_s),
        .lk_req(lk_req), .lk_x(lk_x), .lk_y(lk_y), .lk_ack(lk_ack), .lk_hit(lk_hit),
        .collision(collision), .coll_valid(coll_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    function automatic bit hit_map(int x, int y);
        return (x == 169 && y == 240) || (x == 300 && y == 111);
    endfunction

    // Zero-wait responder; one coordinate can be made to never ack.
    assign lk_hit = hit_map(int'(lk_x), int'(lk_y));
    assign lk_ack = lk_req ? !(na_en && lk_x == na_x && lk_y == na_y) : stray_ack;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model + compare process ----------------
    typedef struct { int x; int y; int len; } probe_t;
    probe_t exp_q[$];
    probe_t cur;
    probe_t seen_q[$];
    int  exp_coll, exp_cyc, cyc, run_len, max_run, n_cv, last_cyc;
    bit  in_sweep, prev_busy, prev_req;

    task automatic build_model();
        int x, y, s, px, py, b;
        bit oob;
        probe_t p;
        exp_q.delete();
        exp_coll = 0;
        exp_cyc  = 2;
        for (int i = 0; i < N; i++) begin
            x = int'(req_x[i*10 +: 10]);
            y = int'(req_y[i*10 +: 10]);
            s = int'(req_s[i*10 +: 10]);
            for (int d = 0; d < 4; d++) begin
                px = x; py = y;
                case (d)
                    0: px = x + s + 1;
                    1: px = x - s - 1;
                    2: py = y + s + 1;
                    default: py = y - s - 1;
                endcase
                oob = (px < 0) || (px > 639) || (py < 0) || (py > 479);
                if (oob) begin
                    b = 1; exp_cyc += 2;
                end else if (na_en && px == int'(na_x) && py == int'(na_y)) begin
                    b = 1; exp_cyc += 2 + TMO;
                    p.x = px; p.y = py; p.len = TMO; exp_q.push_back(p);
                end else begin
                    b = hit_map(px, py) ? 1 : 0; exp_cyc += 3;
                    p.x = px; p.y = py; p.len = 1; exp_q.push_back(p);
                end
                exp_coll |= b << (i*4 + d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (Reset) begin
            exp_q.delete();
            in_sweep  = 1'b0;
            prev_busy = 1'b0;
            prev_req  = 1'b0;
            run_len   = 0;
        end else begin
            if (busy && !prev_busy) begin
                build_model();
                in_sweep = 1'b1;
                cyc = 0;
            end else if (in_sweep) begin
                cyc++;
            end
            if (lk_req) begin
                if (!prev_req) begin
                    run_len = 1;
                    cur.x = lk_x; cur.y = lk_y; seen_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_probe", int'(lk_x), -1);
                        cur.len = 0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end else begin
                    run_len++;
                end
                chk("lk_x", int'(lk_x), cur.x);
                chk("lk_y", int'(lk_y), cur.y);
            end else if (prev_req) begin
                chk("req_cycles", run_len, cur.len);
                if (run_len > max_run) max_run = run_len;
            end
            if (coll_valid) begin
                n_cv++;
                if (!in_sweep) begin
                    chk("coll_valid_outside_sweep", 1, 0);
                end else begin
                    chk("collision", int'(collision), exp_coll);
                    chk("sweep_cycles", cyc, exp_cyc);
                    chk("probes_left", exp_q.size(), 0);
                    last_cyc = cyc;
                    in_sweep = 1'b0;
                end
            end
            prev_busy = busy;
            prev_req  = lk_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_pos(input int i, input int x, input int y, input int s);
        req_x[i*10 +: 10] = 10'(x);
        req_y[i*10 +: 10] = 10'(y);
        req_s[i*10 +: 10] = 10'(s);
    endtask

    task automatic pos_a();
        set_pos(0, 160, 240, 8);
        set_pos(1, 320, 240, 8);
        set_pos(2, 300, 120, 8);
        set_pos(3, 480, 300, 4);
    endtask

    task automatic start_frame();
        frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b0;
    endtask

    task automatic wait_cv(input string name, input int budget);
        int n0;
        int k;
        n0 = n_cv;
        k = 0;
        while (n_cv == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_cv == n0) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n0;
        int k;
        n_cv = 0; max_run = 0; last_cyc = -1;
        pos_a();
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_collision", int'(collision), 16'hFFFF);
        chk("rst_lk_req", int'(lk_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_coll_valid", int'(coll_valid), 0);
        chk("rst_overrun", int'(overrun), 0);

        // A: mid-screen, one hit to the right of tank0, one above shell0
        seen_q.delete();
        start_frame();
        wait_cv("A", 200);
        #1;
        chk("A_collision", int'(collision), 16'h0801);
        chk("A_sweep_cycles", last_cyc, 50);
        chk("A_cv_count", n_cv, 1);
        chk("A_probe_count", seen_q.size(), 16);
        if (seen_q.size() >= 4) begin
            chk("A_p0_x", seen_q[0].x, 169); chk("A_p0_y", seen_q[0].y, 240);
            chk("A_p1_x", seen_q[1].x, 151); chk("A_p1_y", seen_q[1].y, 240);
            chk("A_p2_x", seen_q[2].x, 160); chk("A_p2_y", seen_q[2].y, 249);
            chk("A_p3_x", seen_q[3].x, 160); chk("A_p3_y", seen_q[3].y, 231);
        end
        chk("A_busy_after", int'(busy), 0);

        // B: screen edges, with stray acks between requests
        set_pos(0, 5, 240, 8);
        set_pos(3, 635, 475, 4);
        stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_frame();
        wait_cv("B", 200);
        #1;
        chk("B_collision", int'(collision), 16'h5802);
        chk("B_sweep_cycles", last_cyc, 47);
        chk("B_timeout_err", int'(timeout_err), 0);
        stray_ack = 1'b0;

        // C: tank1's down probe never acknowledged
        pos_a();
        na_en = 1'b1; na_x = 10'd320; na_y = 10'd249;
        max_run = 0;
        repeat (3) @(posedge clk);
        #1 start_frame();
        wait_cv("C", 300);
        #1;
        chk("C_collision", int'(collision), 16'h0841);
        chk("C_sweep_cycles", last_cyc, 64);
        chk("C_max_req_run", max_run, 15);
        chk("C_timeout_err", int'(timeout_err), 1);
        chk("C_overrun_still_clear", int'(overrun), 0);
        na_en = 1'b0;

        // D: edge mid-sweep -> overrun, one queued sweep; a further edge is absorbed
        repeat (3) @(posedge clk);
        #1;
        n0 = n_cv;
        start_frame();
        repeat (18) @(posedge clk);
        #1 frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b0;
        chk("D_overrun", int'(overrun), 1);
        repeat (5) @(posedge clk);
        #1 frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b0;
        wait_cv("D1", 200);
        #1;
        chk("D_second_sweep_start", int'(busy), 1);
        wait_cv("D2", 200);
        repeat (80) @(posedge clk);
        #1;
        chk("D_cv_count", n_cv - n0, 2);
        chk("D_busy_idle", int'(busy), 0);

        // E: reset during a long REQ
        na_en = 1'b1; na_x = 10'd169; na_y = 10'd240;
        start_frame();
        k = 0;
        while (!lk_req && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("E_reached_req", int'(lk_req), 1);
        @(posedge clk);
        #1 Reset = 1'b1;
        #1;
        chk("E_lk_req_drop", int'(lk_req), 0);
        chk("E_collision", int'(collision), 16'hFFFF);
        chk("E_busy", int'(busy), 0);
        chk("E_overrun", int'(overrun), 0);
        chk("E_timeout_err", int'(timeout_err), 0);
        na_en = 1'b0;
        @(posedge clk);
        #1 Reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_frame();
        wait_cv("E_recover", 200);
        #1;
        chk("E_recover_collision", int'(collision), 16'h0801);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
